// File: rtl/de_coder_config_sequencer.sv
// de_coder_config_sequencer
//   Power-up configuration sequencer for the video decoder. Walks a register
//   table of {sub_addr_h, sub_addr_l, data} entries and issues one I2C write
//   per entry to the I2C controller (write / ready / errory handshake). A hung
//   or failed write (errory, or no ready within TIMEOUT_CYC) is recovered by a
//   2-cycle controller reset and retried; after MAX_RETRY attempts on one
//   entry the sequencer parks in FAIL, otherwise it ends in DONE.
//
// Ports
//   clk         in   system clock
//   reset       in   asynchronous active-high reset (sequence auto-starts on release)
//   start       in   restart the sequence; honoured only in DONE / FAIL
//   tbl_idx     out  current table index (registered)
//   tbl_data    in   {sub_h, sub_l, data} for tbl_idx, combinational
//   write       out  one-cycle write request
//   dev_addr    out  device address byte (constant DEV_ADDR)
//   sub_addr_h  out  sub-address high byte, held from ISSUE until ready/error
//   sub_addr_l  out  sub-address low byte
//   wr_data     out  data byte
//   ready       in   controller write complete (1-cycle pulse)
//   errory      in   controller error level, held until controller reset
//   i2c_reset   out  controller reset, 2-cycle pulse during recovery
//   busy        out  high except in DONE / FAIL
//   done        out  all entries written
//   fail        out  an entry exhausted its retries
//   err_idx     out  index of the failing entry, valid while fail=1
//
// Optional feature (macro DCFG_DELAY_CMD_EN)
//   When defined, an entry whose sub-address is 16'hFFFF is a delay command:
//   no write is issued and the sequencer waits data*256 cycles instead.
//   When undefined, 16'hFFFF is written like any other sub-address.

module de_coder_config_sequencer #(
  parameter int         NUM_REGS    = 16,
  parameter int         IDX_W       = 4,
  parameter logic [7:0] DEV_ADDR    = 8'h40,
  parameter int         SETTLE_CYC  = 1024,
  parameter int         GAP_CYC     = 16,
  parameter int         TIMEOUT_CYC = 65535,
  parameter int         MAX_RETRY   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [IDX_W-1:0] tbl_idx,
  input  logic [23:0]      tbl_data,
  output logic             write,
  output logic [7:0]       dev_addr,
  output logic [7:0]       sub_addr_h,
  output logic [7:0]       sub_addr_l,
  output logic [7:0]       wr_data,
  input  logic             ready,
  input  logic             errory,
  output logic             i2c_reset,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [IDX_W-1:0] err_idx
);

  typedef enum logic [3:0] {
    SETTLE,
    LOAD,
    ISSUE,
    WAIT,
    GAP,
    RECOVER,
    DELAY,
    DONE,
    FAIL
  } stateT;

  // Counters exit on "cnt >= last", so a state lasting N cycles uses N-1 here.
  localparam logic [31:0]      SETTLE_LAST = (SETTLE_CYC  > 1) ? 32'(SETTLE_CYC  - 1) : 32'd0;
  localparam logic [31:0]      GAP_LAST    = (GAP_CYC     > 1) ? 32'(GAP_CYC     - 1) : 32'd0;
  localparam logic [31:0]      TMO_LAST    = (TIMEOUT_CYC > 1) ? 32'(TIMEOUT_CYC - 1) : 32'd0;
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_REGS - 1);
  localparam logic [7:0]       RETRY_MAX   = 8'(MAX_RETRY);

  stateT            state, stateNext;
  logic [31:0]      cnt, cntNext, cntInc;
  logic [IDX_W-1:0] idx, idxNext, advIdx;
  logic [7:0]       retryCnt, retryNext, retryInc;
  logic [IDX_W-1:0] errIdx, errIdxNext;
  logic [7:0]       subH, subL, dataByte;
  logic             loadEn;
  logic             lastEntry;
  stateT            advState;

  // One shared counter serves SETTLE, GAP, WAIT (timeout), RECOVER and DELAY;
  // it is cleared on every state change and saturates instead of wrapping.
  assign cntInc   = (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
  assign retryInc = (retryCnt == 8'hFF) ? retryCnt : retryCnt + 8'd1;

  // Successful completion of an entry (ready, or finished delay command).
  assign lastEntry = (idx == LAST_IDX);
  assign advState  = lastEntry ? DONE : GAP;
  assign advIdx    = lastEntry ? idx : idx + 1'b1;

`ifdef DCFG_DELAY_CMD_EN
  logic        isDelayCmd;
  logic [31:0] delayLast;
  assign isDelayCmd = (tbl_data[23:8] == 16'hFFFF);
  // data*256 cycles; data=0 leaves DELAY after its single entry cycle.
  assign delayLast  = (dataByte == 8'd0) ? 32'd0 : ({16'd0, dataByte, 8'd0} - 32'd1);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= SETTLE;
      cnt      <= 32'd0;
      idx      <= '0;
      retryCnt <= 8'd0;
      errIdx   <= '0;
    end else begin
      state    <= stateNext;
      cnt      <= cntNext;
      idx      <= idxNext;
      retryCnt <= retryNext;
      errIdx   <= errIdxNext;
    end
  end

  // Operand registers: captured in LOAD and held through ISSUE/WAIT so the
  // controller sees stable bytes for the whole transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      subH     <= 8'd0;
      subL     <= 8'd0;
      dataByte <= 8'd0;
    end else if (loadEn) begin
      subH     <= tbl_data[23:16];
      subL     <= tbl_data[15:8];
      dataByte <= tbl_data[7:0];
    end
  end

  always_comb begin
    stateNext  = state;
    cntNext    = cnt;
    idxNext    = idx;
    retryNext  = retryCnt;
    errIdxNext = errIdx;
    loadEn     = 1'b0;

    case (state)
      SETTLE: begin
        if (cnt >= SETTLE_LAST) begin
          stateNext = LOAD;
          cntNext   = 32'd0;
        end else begin
          cntNext = cntInc;
        end
      end

      LOAD: begin
        loadEn    = 1'b1;
        cntNext   = 32'd0;
        stateNext = ISSUE;
`ifdef DCFG_DELAY_CMD_EN
        if (isDelayCmd) stateNext = DELAY;
`endif
      end

      ISSUE: begin
        stateNext = WAIT;
        cntNext   = 32'd0;
      end

      // Priority: error, then timeout, then ready.
      WAIT: begin
        if (errory || (cnt >= TMO_LAST)) begin
          stateNext = RECOVER;
          cntNext   = 32'd0;
        end else if (ready) begin
          stateNext = advState;
          idxNext   = advIdx;
          retryNext = 8'd0;
          cntNext   = 32'd0;
        end else begin
          cntNext = cntInc;
        end
      end

      GAP: begin
        if (cnt >= GAP_LAST) begin
          stateNext = LOAD;
          cntNext   = 32'd0;
        end else begin
          cntNext = cntInc;
        end
      end

      // Two cycles of i2c_reset; the attempt is charged on the way out.
      RECOVER: begin
        if (cnt == 32'd0) begin
          cntNext = 32'd1;
        end else begin
          cntNext   = 32'd0;
          retryNext = retryInc;
          if (retryInc >= RETRY_MAX) begin
            stateNext  = FAIL;
            errIdxNext = idx;
          end else begin
            stateNext = GAP;
          end
        end
      end

`ifdef DCFG_DELAY_CMD_EN
      DELAY: begin
        if (cnt >= delayLast) begin
          stateNext = advState;
          idxNext   = advIdx;
          retryNext = 8'd0;
          cntNext   = 32'd0;
        end else begin
          cntNext = cntInc;
        end
      end
`endif

      DONE, FAIL: begin
        if (start) begin
          stateNext = SETTLE;
          cntNext   = 32'd0;
          idxNext   = '0;
          retryNext = 8'd0;
        end
      end

      default: begin
        stateNext = SETTLE;
        cntNext   = 32'd0;
      end
    endcase
  end

  // Outputs decode directly from the state register (glitch-free levels).
  assign write      = (state == ISSUE);
  assign i2c_reset  = (state == RECOVER);
  assign done       = (state == DONE);
  assign fail       = (state == FAIL);
  assign busy       = !((state == DONE) || (state == FAIL));
  assign tbl_idx    = idx;
  assign err_idx    = errIdx;
  assign dev_addr   = DEV_ADDR;
  assign sub_addr_h = subH;
  assign sub_addr_l = subL;
  assign wr_data    = dataByte;

endmodule

// File: tb/tb_de_coder_config_sequencer.sv
// tb_de_coder_config_sequencer
//   Directed bench for de_coder_config_sequencer with a 4-entry table,
//   SETTLE_CYC=20, GAP_CYC=16, TIMEOUT_CYC=100, MAX_RETRY=3.
//   A cycle-stepped slave model answers writes (ack, error, silence, or
//   ready+error together) and logs every write; each test task compares the
//   log and the status outputs with hand-computed cycle numbers.
//   Timing reference: cycle 0 is the falling edge at which reset is released
//   (or start is raised); cycle n is sampled on the n-th falling edge after it.

module tb_de_coder_config_sequencer;

  localparam int S   = 20;   // SETTLE_CYC
  localparam int G   = 16;   // GAP_CYC
  localparam int T   = 100;  // TIMEOUT_CYC
  localparam int LAT = 3;    // slave: ready/errory sampled 3 edges after write

  localparam int M_ACK      = 0;
  localparam int M_ERR_ONCE = 1;
  localparam int M_ERR_ALL  = 2;
  localparam int M_SILENT   = 3;
  localparam int M_BOTH     = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [1:0] tbl_idx;
  logic [23:0] tbl_data;
  logic       write;
  logic [7:0] dev_addr, sub_addr_h, sub_addr_l, wr_data;
  logic       ready = 1'b0;
  logic       errory = 1'b0;
  logic       i2c_reset, busy, done, fail;
  logic [1:0] err_idx;

  logic [23:0] tblMem [0:3];
  assign tbl_data = tblMem[tbl_idx];

  always #5 clk = ~clk;

  de_coder_config_sequencer #(
    .NUM_REGS(4), .IDX_W(2), .DEV_ADDR(8'h40), .SETTLE_CYC(S),
    .GAP_CYC(G), .TIMEOUT_CYC(T), .MAX_RETRY(3)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .tbl_idx(tbl_idx), .tbl_data(tbl_data),
    .write(write), .dev_addr(dev_addr), .sub_addr_h(sub_addr_h), .sub_addr_l(sub_addr_l),
    .wr_data(wr_data), .ready(ready), .errory(errory), .i2c_reset(i2c_reset),
    .busy(busy), .done(done), .fail(fail), .err_idx(err_idx)
  );

  int total = 0;
  int bad = 0;

  // Log filled by run_seq
  int         wrCount;
  int         wrCyc [0:15];
  logic [1:0] wrIdx [0:15];
  logic [7:0] wrH [0:15];
  logic [7:0] wrL [0:15];
  logic [7:0] wrD [0:15];
  int         rstCycles, firstRstCyc, endCyc;
  bit         timedOut;

  task automatic run_seq(input int mode, input int errEntry, input bit viaStart,
                         input int busyStartAt, input int maxCyc);
    int cyc;
    int pendCyc;
    bit pendErr, pendRdy, errUsed, respErr;
    wrCount = 0; rstCycles = 0; firstRstCyc = -1; endCyc = -1; timedOut = 0;
    pendCyc = -1; pendErr = 0; pendRdy = 0; errUsed = 0;
    ready = 0; errory = 0; start = 0;
    if (viaStart) begin
      @(negedge clk);
      start = 1;
    end else begin
      reset = 1;
      @(negedge clk);
      @(negedge clk);
      reset = 0;
    end
    cyc = 0;
    while (cyc < maxCyc && endCyc < 0) begin
      @(negedge clk);
      cyc++;
      start = (cyc == busyStartAt);
      ready = 0;
      if (i2c_reset) begin
        rstCycles++;
        if (firstRstCyc < 0) firstRstCyc = cyc;
        errory = 0;
      end
      if (write) begin
        if (wrCount < 16) begin
          wrCyc[wrCount] = cyc; wrIdx[wrCount] = tbl_idx;
          wrH[wrCount] = sub_addr_h; wrL[wrCount] = sub_addr_l; wrD[wrCount] = wr_data;
        end
        $display("write #%0d cyc=%0d idx=%0d dev=%02h sub=%02h%02h data=%02h",
                 wrCount, cyc, tbl_idx, dev_addr, sub_addr_h, sub_addr_l, wr_data);
        wrCount++;
        respErr = (int'(tbl_idx) == errEntry) &&
                  ((mode == M_ERR_ALL) || ((mode == M_ERR_ONCE || mode == M_BOTH) && !errUsed));
        if (respErr) errUsed = 1;
        if (mode != M_SILENT) begin
          pendCyc = cyc + LAT - 1;
          pendErr = respErr;
          pendRdy = !respErr || (mode == M_BOTH);
        end
      end
      if (cyc == pendCyc) begin
        if (pendErr) errory = 1;
        if (pendRdy) ready = 1;
        pendCyc = -1;
      end
      if (done || fail) endCyc = cyc;
    end
    start = 0; ready = 0; errory = 0;
    if (endCyc < 0) timedOut = 1;
  endtask

  task automatic test_reset();
    #1 reset = 1;
    #1;  // before the first rising clock edge: asynchronous clear only
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL reset_busy: got %b want 1", busy); end
    total++; if (write !== 1'b0 || i2c_reset !== 1'b0) begin bad++; $display("FAIL reset_strobes: got write=%b i2c_reset=%b want 0/0", write, i2c_reset); end
    total++; if (done !== 1'b0 || fail !== 1'b0) begin bad++; $display("FAIL reset_status: got done=%b fail=%b want 0/0", done, fail); end
    total++; if (tbl_idx !== 2'd0 || err_idx !== 2'd0) begin bad++; $display("FAIL reset_idx: got idx=%0d err_idx=%0d want 0/0", tbl_idx, err_idx); end
    total++; if ({sub_addr_h, sub_addr_l, wr_data} !== 24'h0) begin bad++; $display("FAIL reset_operands: got %06h want 000000", {sub_addr_h, sub_addr_l, wr_data}); end
    total++; if (dev_addr !== 8'h40) begin bad++; $display("FAIL dev_addr: got %02h want 40", dev_addr); end
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_ideal();
    run_seq(M_ACK, -1, 0, -1, 3000);
    total++; if (timedOut !== 1'b0) begin bad++; $display("FAIL ideal_timeout: got %b want 0", timedOut); end
    total++; if (wrCount !== 4) begin bad++; $display("FAIL ideal_count: got %0d want 4", wrCount); end
    total++; if (wrCyc[0] !== S + 1) begin bad++; $display("FAIL ideal_first: got %0d want %0d", wrCyc[0], S + 1); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (wrIdx[i] !== 2'(i) || {wrH[i], wrL[i], wrD[i]} !== tblMem[i]) begin
        bad++; $display("FAIL ideal_operands%0d: got idx=%0d %02h%02h%02h want idx=%0d %06h",
                        i, wrIdx[i], wrH[i], wrL[i], wrD[i], i, tblMem[i]);
      end
    end
    for (int i = 1; i < 4; i++) begin
      total++;
      if (wrCyc[i] - wrCyc[i-1] !== LAT + G + 1) begin
        bad++; $display("FAIL ideal_spacing%0d: got %0d want %0d", i, wrCyc[i] - wrCyc[i-1], LAT + G + 1);
      end
    end
    total++; if (endCyc !== wrCyc[3] + LAT) begin bad++; $display("FAIL ideal_done_cyc: got %0d want %0d", endCyc, wrCyc[3] + LAT); end
    total++; if (done !== 1'b1 || busy !== 1'b0 || fail !== 1'b0) begin bad++; $display("FAIL ideal_status: got done=%b busy=%b fail=%b want 1/0/0", done, busy, fail); end
  endtask

  task automatic test_err_once();
    run_seq(M_ERR_ONCE, 2, 0, -1, 3000);
    total++; if (wrCount !== 5) begin bad++; $display("FAIL erronce_count: got %0d want 5", wrCount); end
    total++; if (wrIdx[2] !== 2'd2 || wrIdx[3] !== 2'd2 || wrIdx[4] !== 2'd3) begin bad++; $display("FAIL erronce_idx: got %0d,%0d,%0d want 2,2,3", wrIdx[2], wrIdx[3], wrIdx[4]); end
    total++; if (firstRstCyc !== wrCyc[2] + LAT || rstCycles !== 2) begin bad++; $display("FAIL erronce_i2c_reset: got first=%0d n=%0d want %0d/2", firstRstCyc, rstCycles, wrCyc[2] + LAT); end
    total++; if (wrCyc[3] - wrCyc[2] !== LAT + 2 + G + 1) begin bad++; $display("FAIL erronce_respacing: got %0d want %0d", wrCyc[3] - wrCyc[2], LAT + 2 + G + 1); end
    total++; if (done !== 1'b1 || fail !== 1'b0) begin bad++; $display("FAIL erronce_status: got done=%b fail=%b want 1/0", done, fail); end
  endtask

  task automatic test_retry_exhaust();
    run_seq(M_ERR_ALL, 1, 0, -1, 3000);
    total++; if (wrCount !== 4) begin bad++; $display("FAIL exhaust_count: got %0d want 4", wrCount); end
    total++; if (wrIdx[1] !== 2'd1 || wrIdx[2] !== 2'd1 || wrIdx[3] !== 2'd1) begin bad++; $display("FAIL exhaust_idx: got %0d,%0d,%0d want 1,1,1", wrIdx[1], wrIdx[2], wrIdx[3]); end
    total++; if (rstCycles !== 6) begin bad++; $display("FAIL exhaust_i2c_reset: got %0d want 6", rstCycles); end
    total++; if (endCyc !== wrCyc[3] + LAT + 2) begin bad++; $display("FAIL exhaust_fail_cyc: got %0d want %0d", endCyc, wrCyc[3] + LAT + 2); end
    total++; if (fail !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL exhaust_status: got fail=%b done=%b busy=%b want 1/0/0", fail, done, busy); end
    total++; if (err_idx !== 2'd1) begin bad++; $display("FAIL exhaust_err_idx: got %0d want 1", err_idx); end
  endtask

  task automatic test_timeout();
    run_seq(M_SILENT, -1, 0, -1, 3000);
    total++; if (wrCount !== 3) begin bad++; $display("FAIL timeout_count: got %0d want 3", wrCount); end
    // WAIT lasts exactly T cycles after the write, then RECOVER begins.
    total++; if (firstRstCyc !== wrCyc[0] + T + 1) begin bad++; $display("FAIL timeout_recover_cyc: got %0d want %0d", firstRstCyc, wrCyc[0] + T + 1); end
    total++; if (wrCyc[1] - wrCyc[0] !== T + 2 + G + 2) begin bad++; $display("FAIL timeout_respacing: got %0d want %0d", wrCyc[1] - wrCyc[0], T + 2 + G + 2); end
    total++; if (endCyc !== wrCyc[2] + T + 3) begin bad++; $display("FAIL timeout_fail_cyc: got %0d want %0d", endCyc, wrCyc[2] + T + 3); end
    total++; if (fail !== 1'b1 || err_idx !== 2'd0 || rstCycles !== 6) begin bad++; $display("FAIL timeout_status: got fail=%b err_idx=%0d rst=%0d want 1/0/6", fail, err_idx, rstCycles); end
  endtask

  task automatic test_both_and_start();
    // ready+errory together on entry 0; a start pulse at cycle 30 (in GAP).
    run_seq(M_BOTH, 0, 0, 30, 3000);
    total++; if (wrCount !== 5) begin bad++; $display("FAIL both_count: got %0d want 5", wrCount); end
    total++; if (wrIdx[0] !== 2'd0 || wrIdx[1] !== 2'd0 || wrIdx[4] !== 2'd3) begin bad++; $display("FAIL both_idx: got %0d,%0d,%0d want 0,0,3", wrIdx[0], wrIdx[1], wrIdx[4]); end
    total++; if (rstCycles !== 2) begin bad++; $display("FAIL both_i2c_reset: got %0d want 2", rstCycles); end
    total++; if (wrCyc[4] !== S + 1 + (LAT + 2 + G + 1) + 3 * (LAT + G + 1)) begin bad++; $display("FAIL busy_start_ignored: got %0d want %0d", wrCyc[4], S + 1 + (LAT + 2 + G + 1) + 3 * (LAT + G + 1)); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL both_done: got %b want 1", done); end
    // start in DONE restarts from index 0 after the settle time
    run_seq(M_ACK, -1, 1, -1, 3000);
    total++; if (wrCount !== 4 || wrIdx[0] !== 2'd0) begin bad++; $display("FAIL restart_count: got n=%0d idx0=%0d want 4/0", wrCount, wrIdx[0]); end
    total++; if (wrCyc[0] !== S + 2) begin bad++; $display("FAIL restart_first: got %0d want %0d", wrCyc[0], S + 2); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL restart_done: got %b want 1", done); end
  endtask

  task automatic test_reset_midwrite();
    int  readyAt = -1;
    bit  found = 0;
    reset = 1;
    @(negedge clk);
    reset = 0;
    for (int c = 1; c <= 200 && !found; c++) begin
      @(negedge clk);
      ready = (c == readyAt);
      if (write && tbl_idx == 2'd1) found = 1;
      else if (write) readyAt = c + LAT - 1;
    end
    total++; if (found !== 1'b1) begin bad++; $display("FAIL midwrite_reach: got %b want 1", found); end
    reset = 1;
    #1;
    total++; if (write !== 1'b0 || tbl_idx !== 2'd0 || busy !== 1'b1) begin bad++; $display("FAIL midwrite_clear: got write=%b idx=%0d busy=%b want 0/0/1", write, tbl_idx, busy); end
    total++; if ({sub_addr_h, sub_addr_l, wr_data} !== 24'h0 || i2c_reset !== 1'b0) begin bad++; $display("FAIL midwrite_operands: got %06h i2c_reset=%b want 000000/0", {sub_addr_h, sub_addr_l, wr_data}, i2c_reset); end
    ready = 0;
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_delay_cmd();
    tblMem[2] = 24'hFFFF02;
    run_seq(M_ACK, -1, 0, -1, 5000);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL delay_done: got %b want 1", done); end
`ifdef DCFG_DELAY_CMD_EN
    total++; if (wrCount !== 3 || wrIdx[2] !== 2'd3) begin bad++; $display("FAIL delay_count: got n=%0d idx=%0d want 3/3", wrCount, wrIdx[2]); end
    total++; if (wrCyc[2] - wrCyc[1] !== LAT + G + 1 + 512 + G + 1) begin bad++; $display("FAIL delay_gap: got %0d want %0d", wrCyc[2] - wrCyc[1], LAT + G + 1 + 512 + G + 1); end
`else
    total++; if (wrCount !== 4) begin bad++; $display("FAIL ffff_count: got %0d want 4", wrCount); end
    total++; if (wrH[2] !== 8'hFF || wrL[2] !== 8'hFF || wrD[2] !== 8'h02) begin bad++; $display("FAIL ffff_operands: got %02h%02h%02h want FFFF02", wrH[2], wrL[2], wrD[2]); end
`endif
    tblMem[2] = 24'hABCDEF;
  endtask

  initial begin
    tblMem[0] = 24'h123456;
    tblMem[1] = 24'h010203;
    tblMem[2] = 24'hABCDEF;
    tblMem[3] = 24'h007F80;
    test_reset();
    test_ideal();
    test_err_once();
    test_retry_exhaust();
    test_timeout();
    test_both_and_start();
    test_reset_midwrite();
    test_delay_cmd();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
